// File: rtl/morse_timed_decoder.sv
// Timed Morse decoder: press length picks dot/dash, a release gap closes the letter.
// Define MORSE_DIGITS_EN to decode 5-symbol codes as digits 0-9.
module morse_timed_decoder #(
  parameter int MAX_SYMBOLS      = 5,
  parameter int DOT_MAX_TICKS    = 2,
  parameter int LETTER_GAP_TICKS = 4,
  parameter int CNT_W            = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     TickEn,
  input  logic                     PlayerBtn,
  output logic [2*MAX_SYMBOLS-1:0] MorsePacked,
  output logic [2:0]               SymCount,
  output logic                     MorseReady,
  output logic [7:0]               DecodedLetter,
  output logic                     Overflow,
  output logic [1:0]               fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2,
    EMIT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DUR_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DOT_MAX  = CNT_W'(DOT_MAX_TICKS);
  localparam logic [CNT_W-1:0] GAP_T    = CNT_W'(LETTER_GAP_TICKS);
  localparam logic [2:0]       MAX_S    = 3'(MAX_SYMBOLS);
  localparam logic [2:0]       CNT_SAT  = 3'(MAX_SYMBOLS + 1);

  generate
    if (MAX_SYMBOLS < 4 || MAX_SYMBOLS > 6) begin : g_bad_max
      $error("morse_timed_decoder: MAX_SYMBOLS must be 4..6");
    end
`ifdef MORSE_DIGITS_EN
    if (MAX_SYMBOLS < 5) begin : g_bad_digits
      $error("morse_timed_decoder: MORSE_DIGITS_EN needs MAX_SYMBOLS >= 5");
    end
`endif
  endgenerate

  state_t                   state, state_nx;
  logic                     btn_m, btn_s, btn_p;
  logic                     rise, fall;
  logic [CNT_W-1:0]         dur, dur_nx, dur_inc;
  logic [2*MAX_SYMBOLS-1:0] acc, acc_nx;
  logic [2:0]               sym_cnt, cnt_nx;
  logic                     ovf, ovf_nx;
  logic                     load;
  logic [1:0]               sym;
  logic [5:0]               dash;
  logic [7:0]               letter_dec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      btn_p <= 1'b0;
    end else begin
      btn_m <= PlayerBtn;
      btn_s <= btn_m;
      btn_p <= btn_s;
    end
  end

  assign rise    = btn_s & ~btn_p;
  assign fall    = ~btn_s & btn_p;
  assign dur_inc = (TickEn && dur != DUR_MAX) ? dur + 1'b1 : dur;
  assign sym     = (dur_inc <= DOT_MAX) ? 2'b01 : 2'b11;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Outputs are captured on the gap-closing cycle so they are already valid in EMIT.
  always_comb begin
    state_nx = state;
    dur_nx   = dur;
    acc_nx   = acc;
    cnt_nx   = sym_cnt;
    ovf_nx   = ovf;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nx = PRESS;
          dur_nx   = '0;
        end
      end
      PRESS: begin
        dur_nx = dur_inc;
        if (fall) begin
          if (sym_cnt < MAX_S) begin
            for (int i = 0; i < MAX_SYMBOLS; i++) begin
              if (sym_cnt == i[2:0]) acc_nx[2*i +: 2] = sym;
            end
          end else begin
            ovf_nx = 1'b1;
          end
          cnt_nx   = (sym_cnt == CNT_SAT) ? sym_cnt : sym_cnt + 3'd1;
          dur_nx   = '0;
          state_nx = GAP;
        end
      end
      GAP: begin
        dur_nx = dur_inc;
        if (dur_inc == GAP_T) begin
          load     = 1'b1;
          state_nx = EMIT;
        end else if (rise) begin
          dur_nx   = '0;
          state_nx = PRESS;
        end
      end
      EMIT: begin
        acc_nx   = '0;
        cnt_nx   = '0;
        ovf_nx   = 1'b0;
        dur_nx   = '0;
        state_nx = btn_s ? PRESS : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dur           <= '0;
      acc           <= '0;
      sym_cnt       <= '0;
      ovf           <= 1'b0;
      MorsePacked   <= '0;
      SymCount      <= '0;
      DecodedLetter <= '0;
      Overflow      <= 1'b0;
    end else begin
      dur     <= dur_nx;
      acc     <= acc_nx;
      sym_cnt <= cnt_nx;
      ovf     <= ovf_nx;
      if (load) begin
        MorsePacked   <= acc;
        SymCount      <= sym_cnt;
        DecodedLetter <= letter_dec;
        Overflow      <= ovf;
      end
    end
  end

  // Dash bit i is 1 for a dash in slot i, first symbol in bit 0.
  always_comb begin
    dash = '0;
    for (int i = 0; i < MAX_SYMBOLS; i++) dash[i] = acc[2*i+1];
    letter_dec = 8'h3F;
    if (!ovf) begin
      case (sym_cnt)
        3'd1: letter_dec = dash[0] ? "T" : "E";
        3'd2: begin
          case (dash[1:0])
            2'b00: letter_dec = "I";
            2'b10: letter_dec = "A";
            2'b01: letter_dec = "N";
            2'b11: letter_dec = "M";
            default: ;
          endcase
        end
        3'd3: begin
          case (dash[2:0])
            3'b000: letter_dec = "S";
            3'b100: letter_dec = "U";
            3'b010: letter_dec = "R";
            3'b110: letter_dec = "W";
            3'b001: letter_dec = "D";
            3'b101: letter_dec = "K";
            3'b011: letter_dec = "G";
            3'b111: letter_dec = "O";
            default: ;
          endcase
        end
        3'd4: begin
          case (dash[3:0])
            4'b0000: letter_dec = "H";
            4'b1000: letter_dec = "V";
            4'b0100: letter_dec = "F";
            4'b0010: letter_dec = "L";
            4'b0110: letter_dec = "P";
            4'b1110: letter_dec = "J";
            4'b0001: letter_dec = "B";
            4'b1001: letter_dec = "X";
            4'b0101: letter_dec = "C";
            4'b1101: letter_dec = "Y";
            4'b0011: letter_dec = "Z";
            4'b1011: letter_dec = "Q";
            default: ;
          endcase
        end
`ifdef MORSE_DIGITS_EN
        3'd5: begin
          case (dash[4:0])
            5'b11110: letter_dec = "1";
            5'b11100: letter_dec = "2";
            5'b11000: letter_dec = "3";
            5'b10000: letter_dec = "4";
            5'b00000: letter_dec = "5";
            5'b00001: letter_dec = "6";
            5'b00011: letter_dec = "7";
            5'b00111: letter_dec = "8";
            5'b01111: letter_dec = "9";
            5'b11111: letter_dec = "0";
            default: ;
          endcase
        end
`endif
        default: ;
      endcase
    end
  end

  // MorseReady: one-cycle strobe, no back-pressure; data outputs are valid with it and hold after.
  assign MorseReady = (state == EMIT);
  assign fsm_state  = state;

endmodule

// File: tb/tb_morse_timed_decoder.sv
// Bench for morse_timed_decoder: letters are keyed in, expected results queued, strobes scored.
module tb_morse_timed_decoder;

  localparam int W = 22;

  logic       clk;
  logic       rst;
  logic       TickEn;
  logic       PlayerBtn;
  logic [9:0] MorsePacked;
  logic [2:0] SymCount;
  logic       MorseReady;
  logic [7:0] DecodedLetter;
  logic       Overflow;
  logic [1:0] fsm_state;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  morse_timed_decoder #(
    .MAX_SYMBOLS(5), .DOT_MAX_TICKS(2), .LETTER_GAP_TICKS(4), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .TickEn(TickEn), .PlayerBtn(PlayerBtn),
    .MorsePacked(MorsePacked), .SymCount(SymCount), .MorseReady(MorseReady),
    .DecodedLetter(DecodedLetter), .Overflow(Overflow), .fsm_state(fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (MorseReady) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'(MorseReady), 32'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("packed",   32'(MorsePacked),   32'(e[21:12]));
        check("symcount", 32'(SymCount),      32'(e[11:9]));
        check("letter",   32'(DecodedLetter), 32'(e[8:1]));
        check("overflow", 32'(Overflow),      32'(e[0]));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic btn_hold(input int n);
    PlayerBtn = 1'b1;
    idle(n);
    PlayerBtn = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_packed"},   32'(MorsePacked),   32'd0);
    check({tag, "_symcount"}, 32'(SymCount),      32'd0);
    check({tag, "_letter"},   32'(DecodedLetter), 32'd0);
    check({tag, "_overflow"}, 32'(Overflow),      32'd0);
    check({tag, "_ready"},    32'(MorseReady),    32'd0);
  endtask

  // code: '.' and '-'; dash_ticks fixes dash length unless rnd picks timings.
  task automatic send_letter(input string code, input logic [7:0] letter,
                             input int dash_ticks, input bit rnd);
    logic [9:0]   pk;
    logic [W-1:0] e;
    int n, hold, lat;
    n  = code.len();
    pk = '0;
    for (int i = 0; i < n && i < 5; i++) pk[2*i +: 2] = (code[i] == "-") ? 2'b11 : 2'b01;
    e = {pk, 3'(n > 6 ? 6 : n), letter, (n > 5) ? 1'b1 : 1'b0};
    exp_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      if (code[i] == "-") hold = rnd ? int'($urandom_range(3, 8)) : dash_ticks;
      else                hold = rnd ? int'($urandom_range(1, 2)) : 2;
      btn_hold(hold);
      if (i < n - 1) idle(rnd ? int'($urandom_range(1, 3)) : 2);
    end
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (MorseReady) begin
        lat = k;
        break;
      end
    end
    check({"latency_", code}, 32'(lat), 32'd7);
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    TickEn    = 1'b1;
    PlayerBtn = 1'b0;
    idle(3);
    check_cleared("reset");
    check("reset_state", 32'(fsm_state), 32'd0);
    rst = 1'b1;
    idle(2);

    send_letter("...",  8'h53, 5, 1'b0);
    send_letter("-.-.", 8'h43, 5, 1'b0);
    send_letter(".",    8'h45, 3, 1'b0);
    send_letter("-",    8'h54, 3, 1'b0);
`ifdef MORSE_DIGITS_EN
    send_letter(".....", 8'h35, 5, 1'b0);
`else
    send_letter(".....", 8'h3F, 5, 1'b0);
`endif
    send_letter("......", 8'h3F, 5, 1'b0);
    send_letter(".",      8'h45, 3, 1'b0);
    send_letter("..--",   8'h3F, 5, 1'b0);
    send_letter("-",      8'h54, 300, 1'b0);

    send_letter("-...", 8'h42, 5, 1'b1);
    send_letter(".--.", 8'h50, 5, 1'b1);
    send_letter("--.-", 8'h51, 5, 1'b1);
    send_letter(".-",   8'h41, 5, 1'b1);
    send_letter(".--",  8'h57, 5, 1'b1);
    send_letter("-.--", 8'h59, 5, 1'b1);
    idle(10);
    check("hold_letter", 32'(DecodedLetter), 32'h59);

    // Reset while the second symbol is being held: partial letter must vanish.
    btn_hold(2);
    idle(2);
    PlayerBtn = 1'b1;
    idle(2);
    rst       = 1'b0;
    PlayerBtn = 1'b0;
    idle(3);
    check_cleared("midrst");
    rst = 1'b1;
    idle(20);
    check_cleared("postrst");
    send_letter("-", 8'h54, 3, 1'b0);

    idle(5);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
